// File: rtl/rggen_apb_bridge.sv
// Local command to APB initiator bridge: one local command becomes one APB transfer.
// Optional ACCESS-phase timeout is built when RGGEN_APB_BRIDGE_TIMEOUT_EN is defined.
module rggen_apb_bridge #(
  parameter int DATA_WIDTH          = 32,
  parameter int LOCAL_ADDRESS_WIDTH = 16,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES      = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_command_valid,
  input  logic                           i_write,
  input  logic [LOCAL_ADDRESS_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH/8-1:0]        i_strobe,
  input  logic [DATA_WIDTH-1:0]          i_write_data,
  output logic                           o_response_ready,
  output logic [DATA_WIDTH-1:0]          o_read_data,
  output logic [1:0]                     o_status,
  output logic                           o_psel,
  output logic                           o_penable,
  output logic                           o_pwrite,
  output logic [HOST_ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                     o_pprot,
  output logic [DATA_WIDTH-1:0]          o_pwdata,
  output logic [DATA_WIDTH/8-1:0]        o_pstrb,
  input  logic                           i_pready,
  input  logic [DATA_WIDTH-1:0]          i_prdata,
  input  logic                           i_pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] ACCESS  = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]                    r_state;
  logic                          r_psel;
  logic                          r_penable;
  logic                          r_pwrite;
  logic [HOST_ADDRESS_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0]         r_pwdata;
  logic [STRB_WIDTH-1:0]         r_pstrb;
  logic                          r_response_ready;
  logic [DATA_WIDTH-1:0]         r_read_data;
  logic [1:0]                    r_status;

  logic [HOST_ADDRESS_WIDTH-1:0] w_paddr;
  logic                          w_timeout;

  assign w_paddr = HOST_ADDRESS_WIDTH'(i_address);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_state == SETUP) begin
      r_count <= '0;
    end else if ((r_state == ACCESS) && !i_pready) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the last allowed wait cycle so the abort lands after TIMEOUT_CYCLES ACCESS cycles.
  assign w_timeout = (r_state == ACCESS) && !i_pready &&
                     (r_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  logic w_timeout_unused;

  assign w_timeout_unused = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_psel           <= 1'b0;
      r_penable        <= 1'b0;
      r_pwrite         <= 1'b0;
      r_paddr          <= '0;
      r_pwdata         <= '0;
      r_pstrb          <= '0;
      r_response_ready <= 1'b0;
      r_read_data      <= '0;
      r_status         <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_command_valid) begin
            r_state  <= SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= i_write;
            r_paddr  <= w_paddr;
            r_pwdata <= i_write ? i_write_data : '0;
            r_pstrb  <= i_write ? i_strobe : '0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (i_pready) begin
            r_state          <= RESPOND;
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_response_ready <= 1'b1;
            r_read_data      <= r_pwrite ? '0 : i_prdata;
            r_status         <= {1'b0, i_pslverr};
          end else if (w_timeout) begin
            r_state          <= RESPOND;
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_response_ready <= 1'b1;
            r_read_data      <= '0;
            r_status         <= 2'b11;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_response_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_psel           = r_psel;
  assign o_penable        = r_penable;
  assign o_pwrite         = r_pwrite;
  assign o_paddr          = r_paddr;
  assign o_pprot          = 3'b000;
  assign o_pwdata         = r_pwdata;
  assign o_pstrb          = r_pstrb;
  assign o_response_ready = r_response_ready;
  assign o_read_data      = r_read_data;
  assign o_status         = r_status;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Directed bench for rggen_apb_bridge: scoreboard of expected responses, APB slave driven inline.
// Build with RGGEN_APB_BRIDGE_TIMEOUT_EN to exercise the timeout path.
module tb_rggen_apb_bridge;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_command_valid = 1'b0;
  logic            i_write = 1'b0;
  logic [AW-1:0]   i_address = '0;
  logic [DW/8-1:0] i_strobe = '0;
  logic [DW-1:0]   i_write_data = '0;
  logic            o_response_ready;
  logic [DW-1:0]   o_read_data;
  logic [1:0]      o_status;
  logic            o_psel;
  logic            o_penable;
  logic            o_pwrite;
  logic [AW-1:0]   o_paddr;
  logic [2:0]      o_pprot;
  logic [DW-1:0]   o_pwdata;
  logic [DW/8-1:0] o_pstrb;
  logic            i_pready = 1'b0;
  logic [DW-1:0]   i_prdata = '0;
  logic            i_pslverr = 1'b0;

  rggen_apb_bridge #(
    .DATA_WIDTH          (DW),
    .LOCAL_ADDRESS_WIDTH (AW),
    .HOST_ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_command_valid  (i_command_valid),
    .i_write          (i_write),
    .i_address        (i_address),
    .i_strobe         (i_strobe),
    .i_write_data     (i_write_data),
    .o_response_ready (o_response_ready),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_prdata         (i_prdata),
    .i_pslverr        (i_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    status;
  } resp_t;

  resp_t           sb_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  logic            cur_write;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [DW/8-1:0] cur_strb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb);
    i_command_valid = 1'b1;
    i_write         = wr;
    i_address       = addr;
    i_write_data    = data;
    i_strobe        = strb;
    cur_write       = wr;
    cur_addr        = addr;
    cur_wdata       = data;
    cur_strb        = strb;
  endtask

  // waits < 0 means the slave never answers (timeout expected).
  task automatic run_xfer(input string tag, input int waits, input logic [DW-1:0] rdata,
                          input logic slverr, input logic keep_valid, input int exp_acc);
    int    setups = 0;
    int    accs   = 0;
    int    lat    = -1;
    resp_t exp_r;
    resp_t got_r;
    got_r = '0;
    if (waits < 0) begin
      exp_r.rdata  = '0;
      exp_r.status = 2'b11;
    end else begin
      exp_r.rdata  = cur_write ? '0 : rdata;
      exp_r.status = {1'b0, slverr};
    end
    sb_q.push_back(exp_r);
    i_pready = 1'b0;
    for (int cyc = 0; cyc < 200 && lat < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check({tag, " idle_psel"}, 64'(o_psel), 64'd0);
      if (o_psel) begin
        check({tag, " pwrite"}, 64'(o_pwrite), 64'(cur_write));
        check({tag, " paddr"}, 64'(o_paddr), 64'(cur_addr));
        check({tag, " pwdata"}, 64'(o_pwdata), cur_write ? 64'(cur_wdata) : 64'd0);
        check({tag, " pstrb"}, 64'(o_pstrb), cur_write ? 64'(cur_strb) : 64'd0);
        if (!o_penable) begin
          setups++;
          check({tag, " pprot"}, 64'(o_pprot), 64'd0);
          i_address = ~cur_addr;
          // Out-of-ACCESS pready/pslverr must be ignored.
          i_pready  = 1'b1;
          i_pslverr = 1'b1;
        end else begin
          accs++;
          if (accs == waits + 1) begin
            i_pready  = 1'b1;
            i_prdata  = rdata;
            i_pslverr = slverr;
          end else begin
            i_pready  = 1'b0;
            i_prdata  = $urandom;
            i_pslverr = 1'($urandom);
          end
        end
      end
      if (o_response_ready) begin
        lat   = cyc;
        got_r = {o_read_data, o_status};
      end
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    if (!keep_valid) i_command_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(2 + exp_acc));
    check({tag, " setups"}, 64'(setups), 64'd1);
    check({tag, " access_cycles"}, 64'(accs), 64'(exp_acc));
    if (lat >= 0 && sb_q.size() > 0) begin
      exp_r = sb_q.pop_front();
      check({tag, " read_data"}, 64'(got_r.rdata), 64'(exp_r.rdata));
      check({tag, " status"}, 64'(got_r.status), 64'(exp_r.status));
    end
    if (!keep_valid) begin
      @(negedge clk);
      check({tag, " pulse_width"}, 64'(o_response_ready), 64'd0);
      check({tag, " idle_psel_after"}, 64'(o_psel), 64'd0);
    end
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst psel", 64'(o_psel), 64'd0);
    check("rst penable", 64'(o_penable), 64'd0);
    check("rst response", 64'(o_response_ready), 64'd0);
    check("rst status", 64'(o_status), 64'd0);
    check("rst read_data", 64'(o_read_data), 64'd0);
    check("rst paddr", 64'(o_paddr), 64'd0);
    check("rst pwdata", 64'(o_pwdata), 64'd0);
    check("rst pstrb", 64'(o_pstrb), 64'd0);
    check("rst pwrite", 64'(o_pwrite), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    @(posedge clk); #1;
    start_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    run_xfer("wr0", 0, 32'h0, 1'b0, 1'b0, 1);

    @(posedge clk); #1;
    start_cmd(1'b0, 16'h0020, 32'hCAFEF00D, 4'hF);
    run_xfer("rd3", 3, 32'h12345678, 1'b0, 1'b0, 4);

    @(posedge clk); #1;
    start_cmd(1'b1, 16'h0030, 32'hA5A5A5A5, 4'h3);
    run_xfer("slverr", 0, 32'hFFFFFFFF, 1'b1, 1'b0, 1);

    // Valid stays high across the first transfer and straight into the second.
    @(posedge clk); #1;
    start_cmd(1'b1, 16'h0040, 32'h11111111, 4'hF);
    run_xfer("b2b_a", 1, 32'h0, 1'b0, 1'b1, 2);
    start_cmd(1'b0, 16'h0044, 32'h22222222, 4'h5);
    run_xfer("b2b_b", 0, 32'h87654321, 1'b0, 1'b0, 1);

    @(posedge clk); #1;
    start_cmd(1'b0, 16'h0050, 32'h0, 4'hF);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (o_penable) seen = 1'b1;
    end
    check("midrst reached_access", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst psel", 64'(o_psel), 64'd0);
    check("midrst penable", 64'(o_penable), 64'd0);
    check("midrst response", 64'(o_response_ready), 64'd0);
    i_command_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_cmd(1'b0, 16'h0060, 32'h0, 4'hF);
    run_xfer("post_rst", 2, 32'h0BADCAFE, 1'b0, 1'b0, 3);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    @(posedge clk); #1;
    start_cmd(1'b0, 16'h0070, 32'h0, 4'hF);
    i_prdata = 32'hFFFF0000;
    run_xfer("timeout", -1, 32'hFFFF0000, 1'b0, 1'b0, TO);
`else
    @(posedge clk); #1;
    start_cmd(1'b0, 16'h0070, 32'h0, 4'hF);
    i_pready = 1'b0;
    repeat (100) @(negedge clk);
    check("no_timeout psel", 64'(o_psel), 64'd1);
    check("no_timeout penable", 64'(o_penable), 64'd1);
    check("no_timeout response", 64'(o_response_ready), 64'd0);
    check("no_timeout status", 64'(o_status), 64'd0);
    i_command_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
